// File: rtl/fnn_pkg.sv
// Shared definitions for the network datapath: drain FSM states and default vector geometry.
package fnn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

    localparam int NEURON_NO  = 10;
    localparam int DATA_WIDTH = 16;

endpackage

// File: rtl/last_layer_drain_if.sv
// Valid/ready beat stream carrying one neuron value, its index and a last flag.
interface last_layer_drain_if #(
    parameter int neuronNo  = fnn_pkg::NEURON_NO,
    parameter int dataWidth = fnn_pkg::DATA_WIDTH
);
    localparam int IDX_W = $clog2(neuronNo);

    logic                        out_valid;
    logic                        out_ready;
    logic signed [dataWidth-1:0] out_data;
    logic [IDX_W-1:0]            out_index;
    logic                        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/last_layer_argmax.sv
// Serial running-max tracker over accepted beats; reports the winning index after the last beat.
module last_layer_argmax
    import fnn_pkg::*;
#(
    parameter int neuronNo  = NEURON_NO,
    parameter int dataWidth = DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [dataWidth-1:0] i_data,
    input  logic [$clog2(neuronNo)-1:0] i_idx,
    input  logic                        i_hs,
    input  logic                        i_last,
    output logic [$clog2(neuronNo)-1:0] o_class_id,
    output logic                        o_class_valid
);
    localparam int IDX_W = $clog2(neuronNo);

    logic signed [dataWidth-1:0] r_max;
    logic [IDX_W-1:0]            r_max_idx;
    logic [IDX_W-1:0]            r_class_id;
    logic                        r_class_valid;
    logic                        w_take;
    logic [IDX_W-1:0]            w_run_idx;

    // Strict greater-than keeps the earlier index on ties; beat 0 always seeds the tracker.
    assign w_take    = (i_idx == '0) || (i_data > r_max);
    assign w_run_idx = w_take ? i_idx : r_max_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max         <= '0;
            r_max_idx     <= '0;
            r_class_id    <= '0;
            r_class_valid <= 1'b0;
        end else begin
            r_class_valid <= i_hs && i_last;
            if (i_hs) begin
                if (w_take) begin
                    r_max     <= i_data;
                    r_max_idx <= i_idx;
                end
                if (i_last) begin
                    r_class_id <= w_run_idx;
                end
            end
        end
    end

    assign o_class_id    = r_class_id;
    assign o_class_valid = r_class_valid;

endmodule

// File: rtl/last_layer_drain.sv
// Captures the final layer output vector on done_in and streams it one neuron per beat.
// Optional argmax classification outputs are enabled with LAST_LAYER_ARGMAX_EN.
module last_layer_drain
    import fnn_pkg::*;
#(
    parameter int neuronNo  = NEURON_NO,
    parameter int dataWidth = DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done_in,
    input  logic [neuronNo*dataWidth-1:0] layer_in,
    last_layer_drain_if.master            out_if,
    output logic                          busy,
    output logic                          overrun
`ifdef LAST_LAYER_ARGMAX_EN
    ,
    output logic [$clog2(neuronNo)-1:0]   class_id,
    output logic                          class_valid
`endif
);
    localparam int               IDX_W    = $clog2(neuronNo);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(neuronNo - 1);

    drain_state_t                r_state;
    drain_state_t                w_next;
    logic signed [dataWidth-1:0] r_shadow [neuronNo];
    logic [IDX_W-1:0]            r_idx;
    logic                        r_armed;
    logic                        r_overrun;

    logic                        w_capture;
    logic                        w_drop;
    logic                        w_hs;
    logic                        w_last;
    logic signed [dataWidth-1:0] w_beat_data;

    // A rising done_in while still sending is dropped but still consumes the arm.
    assign w_capture   = (r_state == IDLE) && done_in && r_armed;
    assign w_drop      = (r_state == SEND) && done_in && r_armed;
    assign w_hs        = (r_state == SEND) && out_if.out_ready;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_beat_data = r_shadow[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_capture)        w_next = SEND;
            SEND:    if (w_hs && w_last)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < neuronNo; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < neuronNo; i++) begin
                r_shadow[i] <= layer_in[i*dataWidth +: dataWidth];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Re-arm only after done_in is seen low, so a held level yields one capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (!done_in) begin
                r_armed <= 1'b1;
            end else if (w_capture || w_drop) begin
                r_armed <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_if.out_valid = (r_state == SEND);
    assign out_if.out_data  = (r_state == SEND) ? w_beat_data : '0;
    assign out_if.out_index = r_idx;
    assign out_if.out_last  = (r_state == SEND) && w_last;
    assign busy             = (r_state == SEND);
    assign overrun          = r_overrun;

`ifdef LAST_LAYER_ARGMAX_EN
    last_layer_argmax #(
        .neuronNo  (neuronNo),
        .dataWidth (dataWidth)
    ) u_argmax (
        .clk           (clk),
        .rst           (rst),
        .i_data        (w_beat_data),
        .i_idx         (r_idx),
        .i_hs          (w_hs),
        .i_last        (w_last),
        .o_class_id    (class_id),
        .o_class_valid (class_valid)
    );
`endif

endmodule

// File: tb/tb_last_layer_drain.sv
// Randomized self-checking bench for last_layer_drain against a vector/queue reference model.
module tb_last_layer_drain;
    localparam int N  = 10;
    localparam int W  = 16;
    localparam int IW = $clog2(N);

    logic           clk;
    logic           rst;
    logic           done_in;
    logic [N*W-1:0] layer_in;
    logic           busy;
    logic           overrun;
`ifdef LAST_LAYER_ARGMAX_EN
    logic [IW-1:0]  class_id;
    logic           class_valid;
`endif

    last_layer_drain_if #(.neuronNo(N), .dataWidth(W)) sif ();

    last_layer_drain #(.neuronNo(N), .dataWidth(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .done_in  (done_in),
        .layer_in (layer_in),
        .out_if   (sif),
        .busy     (busy),
        .overrun  (overrun)
`ifdef LAST_LAYER_ARGMAX_EN
        ,
        .class_id    (class_id),
        .class_valid (class_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [W-1:0] vec_a [N];
    logic signed [W-1:0] vec_b [N];
    logic [N*W-1:0]      bus_a;
    logic [N*W-1:0]      bus_b;

    logic signed [W-1:0] got_d [$];
    int                  got_i [$];
    bit                  got_l [$];
    logic signed [W-1:0] stall_d [$];
    int                  stall_i [$];
    int                  stall_pos [$];
    int                  col_cycles;
    int                  col_beats;

    task automatic pack_vectors();
        for (int i = 0; i < N; i++) begin
            bus_a[i*W +: W] = vec_a[i];
            bus_b[i*W +: W] = vec_b[i];
        end
    endtask

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < N; i++) begin
            if (vec_a[i] > vec_a[best]) best = i;
        end
        return best;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives ready/done per cycle and records accepted beats and stalled observations.
    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random. done_in high for cycles [d_lo, d_hi).
    task automatic collect(input int n_beats, input int mode, input int d_lo, input int d_hi,
                           input bit switch_b);
        int beats = 0;
        int cyc = 0;
        bit rdy;
        got_d.delete(); got_i.delete(); got_l.delete();
        stall_d.delete(); stall_i.delete(); stall_pos.delete();
        while (beats < n_beats && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sif.out_ready = rdy;
            done_in = (cyc >= d_lo) && (cyc < d_hi);
            if (switch_b && cyc >= d_lo) layer_in = bus_b;
            if (sif.out_valid) begin
                if (rdy) begin
                    got_d.push_back(sif.out_data);
                    got_i.push_back(int'(sif.out_index));
                    got_l.push_back(sif.out_last);
                    beats++;
                end else begin
                    stall_d.push_back(sif.out_data);
                    stall_i.push_back(int'(sif.out_index));
                    stall_pos.push_back(beats);
                end
            end
            step();
            cyc++;
        end
        done_in    = 1'b0;
        col_cycles = cyc;
        col_beats  = beats;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", sif.out_valid); end
        checks++; if (sif.out_data !== '0) begin errors++; $display("FAIL reset_data got %0d want 0", sif.out_data); end
        checks++; if (sif.out_index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", sif.out_index); end
        checks++; if (sif.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", sif.out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) vec_a[i] = 16'(i * 100);
        pack_vectors();
        layer_in = bus_a;
        sif.out_ready = 1'b1;
        done_in = 1'b1;
        step();
        checks++; if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_first_valid got valid=%0b busy=%0b want 1 1", sif.out_valid, busy); end
        checks++; if (sif.out_index !== '0 || sif.out_data !== vec_a[0]) begin errors++; $display("FAIL basic_first_beat got idx=%0d data=%0d want 0 %0d", sif.out_index, sif.out_data, vec_a[0]); end
        collect(N, 0, 0, 2, 1'b0);
        checks++; if (col_beats != N) begin errors++; $display("FAIL basic_beats got %0d want %0d", col_beats, N); end
        checks++; if (col_cycles != N) begin errors++; $display("FAIL basic_cycles got %0d want %0d", col_cycles, N); end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++; if (got_d[k] !== vec_a[k] || got_i[k] != k || got_l[k] != (k == N-1)) begin
                errors++; $display("FAIL basic_beat%0d got data=%0d idx=%0d last=%0b want %0d %0d %0b", k, got_d[k], got_i[k], got_l[k], vec_a[k], k, (k == N-1));
            end
        end
        checks++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_end got busy=%0b valid=%0b want 0 0", busy, sif.out_valid); end
        repeat (3) step();
        checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_capture got valid=%0b want 0", sif.out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_stall();
        layer_in = bus_a;
        done_in = 1'b1;
        step();
        collect(N, 1, 0, 1, 1'b0);
        checks++; if (col_beats != N) begin errors++; $display("FAIL stall_beats got %0d want %0d", col_beats, N); end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++; if (got_d[k] !== vec_a[k] || got_i[k] != k) begin
                errors++; $display("FAIL stall_beat%0d got data=%0d idx=%0d want %0d %0d", k, got_d[k], got_i[k], vec_a[k], k);
            end
        end
        checks++; if (stall_d.size() == 0) begin errors++; $display("FAIL stall_seen got 0 stalled cycles want >0"); end
        for (int k = 0; k < stall_d.size(); k++) begin
            checks++; if (stall_d[k] !== vec_a[stall_pos[k]] || stall_i[k] != stall_pos[k]) begin
                errors++; $display("FAIL stall_hold%0d got data=%0d idx=%0d want %0d %0d", k, stall_d[k], stall_i[k], vec_a[stall_pos[k]], stall_pos[k]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy got %0b want 0", busy); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < N; i++) begin
            vec_a[i] = 16'($urandom);
            vec_b[i] = ~vec_a[i];
        end
        pack_vectors();
        layer_in = bus_a;
        done_in = 1'b1;
        step();
        collect(N, 2, 3, 5, 1'b1);
        checks++; if (col_beats != N) begin errors++; $display("FAIL ovr_beats got %0d want %0d", col_beats, N); end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++; if (got_d[k] !== vec_a[k] || got_i[k] != k) begin
                errors++; $display("FAIL ovr_beat%0d got data=%0d idx=%0d want %0d %0d", k, got_d[k], got_i[k], vec_a[k], k);
            end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", overrun); end
        repeat (4) step();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b want 1", overrun); end
        checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_no_capture got valid=%0b want 0", sif.out_valid); end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < N; i++) begin
            vec_a[i] = 16'($urandom);
            vec_b[i] = 16'($urandom);
        end
        pack_vectors();
        layer_in = bus_a;
        done_in = 1'b1;
        step();
        collect(5, 0, 0, 0, 1'b0);
        checks++; if (col_beats != 5 || sif.out_index !== IW'(5)) begin errors++; $display("FAIL rstmid_pre got beats=%0d idx=%0d want 5 5", col_beats, sif.out_index); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got valid=%0b busy=%0b want 0 0", sif.out_valid, busy); end
        checks++; if (sif.out_data !== '0 || sif.out_index !== '0 || sif.out_last !== 1'b0) begin errors++; $display("FAIL rstmid_zero got data=%0d idx=%0d last=%0b want 0 0 0", sif.out_data, sif.out_index, sif.out_last); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %0b want 0", overrun); end
        #1 rst = 1'b0;
        step();
        for (int i = 0; i < N; i++) vec_a[i] = vec_b[i];
        pack_vectors();
        layer_in = bus_a;
        done_in = 1'b1;
        step();
        collect(N, 2, 0, 1, 1'b0);
        checks++; if (col_beats != N) begin errors++; $display("FAIL rstmid_beats got %0d want %0d", col_beats, N); end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++; if (got_d[k] !== vec_a[k] || got_i[k] != k) begin
                errors++; $display("FAIL rstmid_beat%0d got data=%0d idx=%0d want %0d %0d", k, got_d[k], got_i[k], vec_a[k], k);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            int hold = $urandom_range(1, 3);
            for (int i = 0; i < N; i++) vec_a[i] = 16'($urandom);
            pack_vectors();
            layer_in = bus_a;
            done_in = 1'b1;
            step();
            checks++; if (sif.out_valid !== 1'b1 || sif.out_index !== '0) begin errors++; $display("FAIL b2b%0d_start got valid=%0b idx=%0d want 1 0", it, sif.out_valid, sif.out_index); end
            collect(N, 2, 0, hold - 1, 1'b0);
            checks++; if (col_beats != N) begin errors++; $display("FAIL b2b%0d_beats got %0d want %0d", it, col_beats, N); end
            for (int k = 0; k < got_d.size(); k++) begin
                checks++; if (got_d[k] !== vec_a[k] || got_i[k] != k || got_l[k] != (k == N-1)) begin
                    errors++; $display("FAIL b2b%0d_beat%0d got data=%0d idx=%0d last=%0b want %0d %0d %0b", it, k, got_d[k], got_i[k], got_l[k], vec_a[k], k, (k == N-1));
                end
            end
            checks++; if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b%0d_end got valid=%0b busy=%0b want 0 0", it, sif.out_valid, busy); end
`ifdef LAST_LAYER_ARGMAX_EN
            checks++; if (class_valid !== 1'b1 || int'(class_id) != ref_argmax()) begin errors++; $display("FAIL b2b%0d_class got valid=%0b id=%0d want 1 %0d", it, class_valid, class_id, ref_argmax()); end
`endif
        end
        step();
    endtask

`ifdef LAST_LAYER_ARGMAX_EN
    task automatic test_argmax();
        int exp_id;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                vec_a[0] = -16'sd5;   vec_a[1] = 16'sd300;    vec_a[2] = 16'sd12;  vec_a[3] = 16'sd300;
                vec_a[4] = -16'sd32768; vec_a[5] = 16'sd1;    vec_a[6] = 16'sd2;   vec_a[7] = 16'sd3;
                vec_a[8] = 16'sd299;  vec_a[9] = 16'sd7;
            end else begin
                vec_a[0] = -16'sd100; vec_a[1] = -16'sd200;   vec_a[2] = -16'sd3;  vec_a[3] = -16'sd50;
                vec_a[4] = -16'sd32768; vec_a[5] = -16'sd7;   vec_a[6] = -16'sd9;  vec_a[7] = -16'sd2;
                vec_a[8] = -16'sd1;   vec_a[9] = -16'sd30;
            end
            exp_id = ref_argmax();
            pack_vectors();
            layer_in = bus_a;
            done_in = 1'b1;
            step();
            checks++; if (class_valid !== 1'b0) begin errors++; $display("FAIL argmax%0d_idle_pulse got %0b want 0", pass, class_valid); end
            collect(N, 0, 0, 1, 1'b0);
            checks++; if (class_valid !== 1'b1 || int'(class_id) != exp_id) begin errors++; $display("FAIL argmax%0d_result got valid=%0b id=%0d want 1 %0d", pass, class_valid, class_id, exp_id); end
            step();
            checks++; if (class_valid !== 1'b0 || int'(class_id) != exp_id) begin errors++; $display("FAIL argmax%0d_hold got valid=%0b id=%0d want 0 %0d", pass, class_valid, class_id, exp_id); end
        end
    endtask
`endif

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        done_in = 1'b0;
        layer_in = '0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            vec_a[i] = '0;
            vec_b[i] = '0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_rst_mid();
        test_back_to_back();
`ifdef LAST_LAYER_ARGMAX_EN
        test_argmax();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
